my_pc16: RTL and testbench

//   16-bit program counter: the register stage directly downstream of my_mux16.

---
 rtl/my_pc16.sv | 174 +++++++++++++++++
 tb/tb_my_pc16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/my_pc16.sv
// -----------------------------------------------------------------------------
// my_pc16 -- 16-bit program counter
//
// Register stage directly downstream of my_mux16. Every rising edge it picks
// the next PC (jump target or increment) and registers it. The registered PC
// drives the instruction-ROM address and the A/D datapath.
//
// Optional feature (compile-time macro MY_PC16_RSTACK_EN):
//   Adds call/ret inputs backed by a STACK_DEPTH-entry return-address stack,
//   plus the occupancy output sp and sticky overflow/underflow flags.
//   With the macro undefined those ports and the storage do not exist.
//
// Parameters
//   WIDTH        PC width in bits; must equal $bits(shortint) (16)
//   RESET_VECTOR value loaded into the PC on reset
//   STACK_DEPTH  return-stack entries (only with MY_PC16_RSTACK_EN)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   in     in   [WIDTH] jump target (normally my_mux16.out)
//   load   in   take jump: out <= in
//   inc    in   advance:   out <= out + 1 (wraps)
//   stall  in   hold every register; overrides all other controls
//   call   in   (RSTACK) push out+1, then out <= in
//   ret    in   (RSTACK) pop: out <= stack top
//   sp     out  (RSTACK) [3] stack occupancy, 0..STACK_DEPTH
//   ovf    out  (RSTACK) sticky: call while full
//   unf    out  (RSTACK) sticky: ret while empty
//   out    out  [WIDTH] current PC (registered)
//
// Priority per edge, highest first:
//   !rst_n > stall > ret > call > load > inc > hold
// -----------------------------------------------------------------------------
module my_pc16 #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter int               STACK_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             stall,
`ifdef MY_PC16_RSTACK_EN
  input  logic             call,
  input  logic             ret,
  output logic [2:0]       sp,
  output logic             ovf,
  output logic             unf,
`endif
  output logic [WIDTH-1:0] out
);

  // One decoded operation per edge; the priority chain lives in one place.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_sel;
  logic [WIDTH-1:0] pc_next;

  // Natural WIDTH-bit wrap: 16'hFFFF + 1 -> 16'h0000, no carry kept.
  assign pc_inc = out + WIDTH'(1);

  // 2:1 next-PC select (jump target vs. increment); load beats inc.
  assign pc_sel = load ? in : pc_inc;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = OP_HOLD;
    if (stall) begin
      op = OP_HOLD;
    end
`ifdef MY_PC16_RSTACK_EN
    else if (ret) begin
      op = OP_RET;
    end
    else if (call) begin
      op = OP_CALL;
    end
`endif
    else if (load) begin
      op = OP_LOAD;
    end
    else if (inc) begin
      op = OP_INC;
    end
  end

`ifdef MY_PC16_RSTACK_EN
  // ---------------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------------
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [2:0]       sp_m1;
  logic             full;
  logic             empty;
  logic             push;
  logic [WIDTH-1:0] stack_top;

  assign full      = (sp == 3'(STACK_DEPTH));
  assign empty     = (sp == 3'd0);
  assign sp_m1     = sp - 3'd1;
  assign stack_top = stack[sp_m1[IDXW-1:0]];
  assign push      = (op == OP_CALL) && !full;

  // NOTE: the stack array has no reset; its contents are meaningless while
  // sp is 0, so resetting it would only add reset fan-out. A push coinciding
  // with reset is still blocked so the discarded call leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack[sp[IDXW-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp  <= 3'd0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      case (op)
        OP_CALL: begin
          if (full) ovf <= 1'b1;
          else      sp  <= sp + 3'd1;
        end
        OP_RET: begin
          if (empty) unf <= 1'b1;
          else       sp  <= sp_m1;
        end
        default: ;
      endcase
    end
  end
`endif

  // Hold mux after the select: only an active operation changes the PC.
  always_comb begin
    pc_next = out;
    case (op)
      OP_INC,
      OP_LOAD: pc_next = pc_sel;
`ifdef MY_PC16_RSTACK_EN
      // A call always jumps, even when the push is dropped on overflow.
      OP_CALL: pc_next = in;
      // A ret on an empty stack leaves the PC where it is.
      OP_RET:  pc_next = empty ? out : stack_top;
`endif
      default: pc_next = out;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= RESET_VECTOR;
    end else begin
      out <= pc_next;
    end
  end

endmodule

// File: tb/tb_my_pc16.sv
// -----------------------------------------------------------------------------
// tb_my_pc16 -- self-checking bench for my_pc16
//
// Directed steps from the behavioural description, then a randomized run.
// Expected values come from a reference model kept here: the PC is a plain
// 16-bit number and the return stack is a queue.
// Build with +define+MY_PC16_RSTACK_EN to exercise the call/ret feature.
// -----------------------------------------------------------------------------
module tb_my_pc16;

  localparam logic [15:0] RV = 16'h0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load, inc, stall;
  logic        call, ret;
  logic [15:0] out;
`ifdef MY_PC16_RSTACK_EN
  logic [2:0]  sp;
  logic        ovf, unf;
`endif

  my_pc16 #(
    .WIDTH        (16),
    .RESET_VECTOR (RV),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .stall (stall),
`ifdef MY_PC16_RSTACK_EN
    .call  (call),
    .ret   (ret),
    .sp    (sp),
    .ovf   (ovf),
    .unf   (unf),
`endif
    .out   (out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_ovf, m_unf;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one edge, written directly from the priority rules.
  task automatic model_edge(input bit r, input bit ld, input bit ic,
                            input bit st, input bit cl, input bit rt,
                            input logic [15:0] d);
    if (!r) begin
      m_pc = RV;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (st) begin
      // everything holds
    end else if (rt) begin
      if (m_stack.size() == 0) m_unf = 1;
      else                     m_pc = m_stack.pop_back();
    end else if (cl) begin
      if (m_stack.size() == DEPTH) m_ovf = 1;
      else                         m_stack.push_back(m_pc + 16'd1);
      m_pc = d;
    end else if (ld) begin
      m_pc = d;
    end else if (ic) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic cycle(input string tag, input bit r, input bit ld,
                       input bit ic, input bit st, input bit cl,
                       input bit rt, input logic [15:0] d);
    bit cl_e, rt_e;
`ifdef MY_PC16_RSTACK_EN
    cl_e = cl;
    rt_e = rt;
`else
    cl_e = 1'b0;
    rt_e = 1'b0;
`endif
    @(negedge clk);
    rst_n = r; load = ld; inc = ic; stall = st;
    call = cl_e; ret = rt_e; in = d;
    model_edge(r, ld, ic, st, cl_e, rt_e, d);
    @(posedge clk);
    #1;
    check({tag, ".out"}, out, m_pc);
`ifdef MY_PC16_RSTACK_EN
    check({tag, ".sp"},  {13'd0, sp},  16'(m_stack.size()));
    check({tag, ".ovf"}, {15'd0, ovf}, {15'd0, m_ovf});
    check({tag, ".unf"}, {15'd0, unf}, {15'd0, m_unf});
`endif
  endtask

  initial begin
    rst_n = 1'b0; in = '0; load = 0; inc = 0; stall = 0; call = 0; ret = 0;
    m_pc = 16'hxxxx; m_ovf = 0; m_unf = 0;

    // 1: reset, then three increments
    cycle("rst",   0, 0, 0, 0, 0, 0, 16'h0);
    check("rst_vec", out, 16'h0000);
    cycle("inc1",  1, 0, 1, 0, 0, 0, 16'h0);
    cycle("inc2",  1, 0, 1, 0, 0, 0, 16'h0);
    cycle("inc3",  1, 0, 1, 0, 0, 0, 16'h0);
    check("inc3_abs", out, 16'h0003);
    cycle("hold",  1, 0, 0, 0, 0, 0, 16'hBEEF);

    // 2: wrap at the top
    cycle("ldfffe", 1, 1, 0, 0, 0, 0, 16'hFFFE);
    cycle("wrap1",  1, 0, 1, 0, 0, 0, 16'h0);
    check("wrap1_abs", out, 16'hFFFF);
    cycle("wrap2",  1, 0, 1, 0, 0, 0, 16'h0);
    check("wrap2_abs", out, 16'h0000);

    // 3: load beats inc; stall beats load
    cycle("ldinc", 1, 1, 1, 0, 0, 0, 16'h1234);
    check("ldinc_abs", out, 16'h1234);
    cycle("stall", 1, 1, 0, 1, 0, 0, 16'h5555);
    check("stall_abs", out, 16'h1234);

    // 4: reset wins over inc on the same edge
    cycle("ld40",  1, 1, 0, 0, 0, 0, 16'h0040);
    cycle("rstinc", 0, 0, 1, 0, 0, 0, 16'h0);
    check("rstinc_abs", out, 16'h0000);

`ifdef MY_PC16_RSTACK_EN
    // 5: nested call/return
    cycle("rel",   1, 0, 0, 0, 0, 0, 16'h0);
    cycle("ld10",  1, 1, 0, 0, 0, 0, 16'h0010);
    cycle("call1", 1, 0, 0, 0, 1, 0, 16'h0100);
    cycle("call2", 1, 0, 0, 0, 1, 0, 16'h0200);
    cycle("ret1",  1, 0, 0, 0, 0, 1, 16'h0);
    check("ret1_abs", out, 16'h0101);
    cycle("ret2",  1, 0, 0, 0, 0, 1, 16'h0);
    check("ret2_abs", out, 16'h0011);

    // 6: underflow, then overflow on the fifth call
    cycle("unf",   1, 0, 0, 0, 0, 1, 16'h0);
    check("unf_abs", {15'd0, unf}, 16'h0001);
    for (int i = 0; i < 5; i++)
      cycle("callN", 1, 0, 0, 0, 1, 0, 16'h0300 + 16'(i));
    check("ovf_abs", {15'd0, ovf}, 16'h0001);
    check("ovf_sp",  {13'd0, sp},  16'h0004);
    check("ovf_out", out, 16'h0304);
    cycle("callret", 1, 1, 1, 0, 1, 1, 16'h7777);
    cycle("stallret", 1, 0, 0, 1, 0, 1, 16'h0);
    cycle("rstcall", 0, 0, 0, 0, 1, 0, 16'h0900);
    check("rst_flags", {14'd0, ovf, unf}, 16'h0000);
`endif

    // Randomized run: biased controls, occasional reset.
    cycle("rel2", 1, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      cycle("rnd",
            ($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0),
            16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case anything above ever blocks.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
